// File: rtl/mem_port_ctrl_if.sv
// Core-side and memory-side signals of the memory port controller.
// master = core/memory environment, slave = controller.
interface mem_port_ctrl_if #(
  parameter int unsigned WORDSIZE  = 16,
  parameter int unsigned ADDRWIDTH = 16
);
  logic                 req;
  logic                 we;
  logic [ADDRWIDTH-1:0] addr;
  logic [WORDSIZE-1:0]  wdata;
  logic                 busy;
  logic [WORDSIZE-1:0]  rdata;
  logic                 rvalid;
  logic                 wdone;
  logic                 halt;
  logic [ADDRWIDTH-1:0] Addr;
  logic                 RD;
  logic                 WR;
  logic [WORDSIZE-1:0]  DataOut;
  logic [WORDSIZE-1:0]  DataIn;

  modport master (
    output req, we, addr, wdata, DataIn,
    input  busy, rdata, rvalid, wdone, halt, Addr, RD, WR, DataOut
  );

  modport slave (
    input  req, we, addr, wdata, DataIn,
    output busy, rdata, rvalid, wdone, halt, Addr, RD, WR, DataOut
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// Memory port controller: turns single-cycle core requests into timed RD/WR
// strobes; an all-ones address halts the port until Reset.
module mem_port_ctrl #(
  parameter int unsigned WORDSIZE  = 16,
  parameter int unsigned ADDRWIDTH = 16,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned WR_LEN    = 2
) (
  input logic            Clk1,
  input logic            Reset,
  mem_port_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, HALT} state_t;

  state_t               state, state_n;
  logic [3:0]           cnt, cnt_n;
  logic                 rd_n, wr_n, rvalid_n, wdone_n, halt_n;
  logic [ADDRWIDTH-1:0] addr_n;
  logic [WORDSIZE-1:0]  dout_n, rdata_n;

  assign bus.busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rd_n     = 1'b0;
    wr_n     = 1'b0;
    rvalid_n = 1'b0;
    wdone_n  = 1'b0;
    halt_n   = bus.halt;
    addr_n   = bus.Addr;
    dout_n   = bus.DataOut;
    rdata_n  = bus.rdata;
    case (state)
      IDLE: begin
        if (bus.req) begin
          addr_n = bus.addr;
          dout_n = bus.wdata;
          if (&bus.addr) begin
            state_n = HALT;
            halt_n  = 1'b1;
          end else if (bus.we) begin
            state_n = WRITE;
            wr_n    = 1'b1;
            cnt_n   = 4'(WR_LEN);
          end else begin
            state_n = READ;
            rd_n    = 1'b1;
            cnt_n   = 4'(RD_LAT);
          end
        end
      end
      // cnt counts remaining strobe cycles including the current one
      READ: begin
        if (cnt == 4'd1) begin
          rdata_n  = bus.DataIn;
          rvalid_n = 1'b1;
          cnt_n    = '0;
          state_n  = IDLE;
        end else begin
          rd_n  = 1'b1;
          cnt_n = cnt - 4'd1;
        end
      end
      WRITE: begin
        if (cnt == 4'd1) begin
          wdone_n = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          wr_n  = 1'b1;
          cnt_n = cnt - 4'd1;
        end
      end
      HALT: state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bus.RD      <= 1'b0;
      bus.WR      <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.wdone   <= 1'b0;
      bus.halt    <= 1'b0;
      bus.Addr    <= '0;
      bus.DataOut <= '0;
      bus.rdata   <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bus.RD      <= rd_n;
      bus.WR      <= wr_n;
      bus.rvalid  <= rvalid_n;
      bus.wdone   <= wdone_n;
      bus.halt    <= halt_n;
      bus.Addr    <= addr_n;
      bus.DataOut <= dout_n;
      bus.rdata   <= rdata_n;
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a behavioural memory and
// hand-computed cycle-by-cycle expectations (RD_LAT=2, WR_LEN=2).
module tb_mem_port_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic overlap_seen = 1'b0;
  int rv_count;

  logic [15:0] mem [0:65535];

  mem_port_ctrl_if #(.WORDSIZE(16), .ADDRWIDTH(16)) bus ();

  mem_port_ctrl #(
    .WORDSIZE(16), .ADDRWIDTH(16), .RD_LAT(2), .WR_LEN(2)
  ) dut (
    .Clk1(clk),
    .Reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.DataIn = mem[bus.Addr];

  always @(posedge clk) if (bus.WR) mem[bus.Addr] <= bus.DataOut;
  always @(negedge clk) if (bus.RD && bus.WR) overlap_seen = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if ({bus.RD, bus.WR} !== 2'b00) begin failures++; $display("FAIL rst_rdwr got=%b exp=00", {bus.RD, bus.WR}); end
    checks++; if ({bus.rvalid, bus.wdone, bus.halt} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {bus.rvalid, bus.wdone, bus.halt}); end
    checks++; if (bus.Addr !== 16'h0000) begin failures++; $display("FAIL rst_addr got=%h exp=0000", bus.Addr); end
    checks++; if (bus.DataOut !== 16'h0000) begin failures++; $display("FAIL rst_dout got=%h exp=0000", bus.DataOut); end
    checks++; if (bus.rdata !== 16'h0000) begin failures++; $display("FAIL rst_rdata got=%h exp=0000", bus.rdata); end
    rst = 1'b0;
  endtask

  // Issued straight after reset release: the first edge must accept it.
  task automatic test_read();
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0010;
    tick();
    bus.req = 1'b0;
    checks++; if ({bus.RD, bus.busy, bus.rvalid} !== 3'b110) begin failures++; $display("FAIL rd_c1 got=%b exp=110", {bus.RD, bus.busy, bus.rvalid}); end
    checks++; if (bus.Addr !== 16'h0010) begin failures++; $display("FAIL rd_addr got=%h exp=0010", bus.Addr); end
    tick();
    checks++; if ({bus.RD, bus.rvalid} !== 2'b10) begin failures++; $display("FAIL rd_c2 got=%b exp=10", {bus.RD, bus.rvalid}); end
    tick();
    checks++; if ({bus.RD, bus.rvalid, bus.busy} !== 3'b010) begin failures++; $display("FAIL rd_c3 got=%b exp=010", {bus.RD, bus.rvalid, bus.busy}); end
    checks++; if (bus.rdata !== 16'h1234) begin failures++; $display("FAIL rd_data got=%h exp=1234", bus.rdata); end
    tick();
    checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL rd_pulse got=%b exp=0", bus.rvalid); end
    checks++; if ({bus.rdata, bus.Addr} !== {16'h1234, 16'h0010}) begin failures++; $display("FAIL rd_hold got=%h exp=12340010", {bus.rdata, bus.Addr}); end
  endtask

  task automatic test_write();
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h0020; bus.wdata = 16'hBEEF;
    tick();
    bus.req = 1'b0; bus.wdata = 16'h0000;
    checks++; if ({bus.WR, bus.RD, bus.busy} !== 3'b101) begin failures++; $display("FAIL wr_c1 got=%b exp=101", {bus.WR, bus.RD, bus.busy}); end
    checks++; if ({bus.Addr, bus.DataOut} !== {16'h0020, 16'hBEEF}) begin failures++; $display("FAIL wr_bus got=%h exp=0020beef", {bus.Addr, bus.DataOut}); end
    tick();
    checks++; if ({bus.WR, bus.wdone} !== 2'b10) begin failures++; $display("FAIL wr_c2 got=%b exp=10", {bus.WR, bus.wdone}); end
    tick();
    checks++; if ({bus.WR, bus.wdone, bus.busy} !== 3'b010) begin failures++; $display("FAIL wr_c3 got=%b exp=010", {bus.WR, bus.wdone, bus.busy}); end
    tick();
    checks++; if (bus.wdone !== 1'b0) begin failures++; $display("FAIL wr_pulse got=%b exp=0", bus.wdone); end
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0020;
    tick();
    bus.req = 1'b0;
    tick(); tick();
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 16'hBEEF}) begin failures++; $display("FAIL wr_readback got=%h exp=1beef", {bus.rvalid, bus.rdata}); end
    tick();
  endtask

  task automatic test_back_to_back();
    overlap_seen = 1'b0;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0001;
    tick();
    bus.req = 1'b0;
    tick(); tick();
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 16'hA5A5}) begin failures++; $display("FAIL b2b_rd got=%h exp=1a5a5", {bus.rvalid, bus.rdata}); end
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h0002; bus.wdata = 16'h5555;
    tick();
    bus.req = 1'b0;
    checks++; if ({bus.WR, bus.RD, bus.rvalid} !== 3'b100) begin failures++; $display("FAIL b2b_wr_start got=%b exp=100", {bus.WR, bus.RD, bus.rvalid}); end
    checks++; if (bus.Addr !== 16'h0002) begin failures++; $display("FAIL b2b_addr got=%h exp=0002", bus.Addr); end
    tick(); tick();
    checks++; if (bus.wdone !== 1'b1) begin failures++; $display("FAIL b2b_wdone got=%b exp=1", bus.wdone); end
    tick();
    checks++; if (mem[16'h0002] !== 16'h5555) begin failures++; $display("FAIL b2b_mem got=%h exp=5555", mem[16'h0002]); end
    checks++; if (overlap_seen !== 1'b0) begin failures++; $display("FAIL b2b_overlap got=%b exp=0", overlap_seen); end
  endtask

  task automatic test_busy_ignore();
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0010;
    tick();
    bus.we = 1'b1; bus.addr = 16'h0030; bus.wdata = 16'h9999;
    tick();
    checks++; if ({bus.RD, bus.WR, bus.Addr} !== {2'b10, 16'h0010}) begin failures++; $display("FAIL busy_hold got=%h exp=20010", {bus.RD, bus.WR, bus.Addr}); end
    tick();
    bus.req = 1'b0;
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 16'h1234}) begin failures++; $display("FAIL busy_rd got=%h exp=11234", {bus.rvalid, bus.rdata}); end
    rv_count = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.rvalid || bus.RD || bus.WR || bus.busy) rv_count++;
    end
    checks++; if (rv_count !== 0) begin failures++; $display("FAIL busy_extra got=%0d exp=0", rv_count); end
  endtask

  task automatic test_reset_mid_read();
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0010;
    tick();
    bus.req = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if ({bus.RD, bus.busy} !== 2'b00) begin failures++; $display("FAIL mid_rst got=%b exp=00", {bus.RD, bus.busy}); end
    checks++; if ({bus.Addr, bus.rdata} !== 32'h0) begin failures++; $display("FAIL mid_rst_regs got=%h exp=0", {bus.Addr, bus.rdata}); end
    tick();
    rst = 1'b0;
    rv_count = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.rvalid || bus.RD) rv_count++;
    end
    checks++; if (rv_count !== 0) begin failures++; $display("FAIL mid_no_rvalid got=%0d exp=0", rv_count); end
    bus.req = 1'b1; bus.addr = 16'h0010;
    tick();
    bus.req = 1'b0;
    tick(); tick();
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 16'h1234}) begin failures++; $display("FAIL mid_reread got=%h exp=11234", {bus.rvalid, bus.rdata}); end
    tick();
  endtask

  task automatic test_halt();
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'hFFFF;
    tick();
    checks++; if ({bus.halt, bus.busy, bus.RD, bus.WR} !== 4'b1100) begin failures++; $display("FAIL halt_enter got=%b exp=1100", {bus.halt, bus.busy, bus.RD, bus.WR}); end
    bus.addr = 16'h0010;
    rv_count = 0;
    for (int i = 0; i < 4; i++) begin
      bus.we = i[0];
      tick();
      if (bus.RD || bus.WR || bus.rvalid || bus.wdone || !bus.halt || !bus.busy) rv_count++;
    end
    bus.req = 1'b0;
    checks++; if (rv_count !== 0) begin failures++; $display("FAIL halt_sticky got=%0d exp=0", rv_count); end
    rst = 1'b1;
    tick();
    checks++; if ({bus.halt, bus.busy} !== 2'b00) begin failures++; $display("FAIL halt_clear got=%b exp=00", {bus.halt, bus.busy}); end
    rst = 1'b0;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0001;
    tick();
    bus.req = 1'b0;
    checks++; if (bus.RD !== 1'b1) begin failures++; $display("FAIL halt_resume got=%b exp=1", bus.RD); end
    tick(); tick();
    checks++; if ({bus.rvalid, bus.rdata} !== {1'b1, 16'hA5A5}) begin failures++; $display("FAIL halt_resume_rd got=%h exp=1a5a5", {bus.rvalid, bus.rdata}); end
  endtask

  initial begin
    mem[16'h0001] = 16'hA5A5;
    mem[16'h0002] = 16'h0000;
    mem[16'h0010] = 16'h1234;
    mem[16'h0020] = 16'h0000;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_read();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
